// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: next-PC codes,
// FSM state encoding and the default reset PC.
package pc_fetch_unit_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_HALT  = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection from the decoder's 2-bit code, plus the
// misaligned-target flag (only a register jump can be misaligned).
module pc_fetch_unit_npc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [25:0]       instr_idx,
  input  logic [31:0]       rs_data,
  input  logic [1:0]        npc_op,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] branch_off;

  assign seq_pc     = pc + ADDR_W'(4);
  // 16-bit word offset, sign-extended and scaled to bytes
  assign branch_off = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (npc_op)
      NPC_PLUS4:  next_pc = seq_pc;
      NPC_BRANCH: next_pc = seq_pc + branch_off;
      NPC_JUMP:   next_pc = {seq_pc[ADDR_W-1:28], instr_idx, 2'b00};
      default:    next_pc = ADDR_W'(rs_data);
    endcase
  end

  assign misaligned = (npc_op == NPC_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the word for the decoder and steps the PC on each commit.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        npc_op,
  input  logic [31:0]       rs_data,
  input  logic              advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              addr_err,
  output logic [31:0]       retired
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       instr_reg;
  logic              instr_valid_reg;
  logic              imem_req_reg;
  logic              addr_err_reg;
  logic [31:0]       retired_reg;
  logic [ADDR_W-1:0] next_pc;
  logic              misaligned;

  pc_fetch_unit_npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
    .pc        (pc_reg),
    .instr_idx (instr_reg[25:0]),
    .rs_data   (rs_data),
    .npc_op    (npc_op),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= ST_FETCH;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
      addr_err_reg    <= 1'b0;
      retired_reg     <= 32'h0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          // The request goes up one edge after reset; acks before that are stale
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            pc_reg          <= next_pc;
            retired_reg     <= retired_reg + 32'd1;
            instr_valid_reg <= 1'b0;
            if (misaligned) begin
              addr_err_reg <= 1'b1;
              state_reg    <= ST_HALT;
            end else begin
              imem_req_reg <= 1'b1;
              state_reg    <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely until the next reset
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
          state_reg       <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + ADDR_W'(4);
  assign addr_err    = addr_err_reg;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural memory and decoder drive
// the DUT, expected fetches/halts are queued and checked by a monitor.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  npc_op;
  logic [31:0] rs_data;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [31:0] retired;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .npc_op     (npc_op),
    .rs_data    (rs_data),
    .advance    (advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .addr_err   (addr_err),
    .retired    (retired)
  );

  typedef struct {
    bit          halt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Behavioural instruction memory with programmable ack latency
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        spur_ack  = 1'b0;
  logic        ack_prev  = 1'b0;

  assign imem_ack   = mem_ack | spur_ack;
  assign imem_rdata = spur_ack ? 32'hDEAD_BEEF : mem_rdata;

  always @(negedge clk) begin
    if (ack_prev && rstn) check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    ack_prev = 1'b0;
    mem_ack  = 1'b0;
    if (!rstn || !imem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(imem_addr);
      wait_cnt  = 0;
      ack_prev  = 1'b1;
    end else begin
      wait_cnt++;
    end
  end

  // Monitor: every new instruction or halt must match the head of the queue
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rstn) begin
      if (instr_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_fetch: got pc %h expected no fetch", pc);
        end else begin
          e = sb.pop_front();
          check("fetch_kind", {31'b0, e.halt}, 32'd0);
          check("fetch_pc", pc, e.pc);
          check("fetch_instr", instr, e.instr);
          check("fetch_pc_plus4", pc_plus4, e.pc + 32'd4);
          check("fetch_retired", retired, e.ret);
          check("fetch_req_low", {31'b0, imem_req}, 32'd0);
          $display("fetch pc=%h instr=%h retired=%0d", pc, instr, retired);
        end
      end
      if (addr_err && !prev_err) begin
        if (sb.size() == 0) begin
          vectors++; errors++;
          $display("FAIL unexpected_halt: got pc %h expected no halt", pc);
        end else begin
          e = sb.pop_front();
          check("halt_kind", {31'b0, e.halt}, 32'd1);
          check("halt_pc", pc, e.pc);
          check("halt_retired", retired, e.ret);
          check("halt_valid_low", {31'b0, instr_valid}, 32'd0);
          check("halt_req_low", {31'b0, imem_req}, 32'd0);
          $display("halt pc=%h retired=%0d", pc, retired);
        end
      end
    end
    prev_valid = instr_valid;
    prev_err   = addr_err;
  end

  // Reference model: architectural PC and retire count
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  function automatic logic [31:0] model_next(input logic [1:0] op, input logic [31:0] cur,
                                             input logic [31:0] ins, input logic [31:0] rs);
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (op)
      2'd0:    return seq;
      2'd1:    return seq + 32'(int'($signed(ins[15:0])) * 4);
      2'd2:    return (seq & 32'hF000_0000) | (32'(ins[25:0]) << 2);
      default: return rs;
    endcase
  endfunction

  task automatic push_next();
    if (m_pc[1:0] != 2'b00) sb.push_back('{halt: 1'b1, pc: m_pc, instr: 32'h0, ret: m_ret});
    else                    sb.push_back('{halt: 1'b0, pc: m_pc, instr: mem_word(m_pc), ret: m_ret});
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      vectors++; errors++;
      $display("FAIL valid_timeout: got instr_valid 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic commit(input logic [1:0] op, input logic [31:0] rs, input int stall);
    wait_valid();
    repeat (stall) @(negedge clk);
    npc_op  = op;
    rs_data = rs;
    advance = 1'b1;
    m_pc    = model_next(op, m_pc, mem_word(m_pc), rs);
    m_ret   = m_ret + 32'd1;
    push_next();
    @(negedge clk);
    advance = 1'b0;
    npc_op  = 2'($urandom);
    rs_data = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rstn = 1'b0; advance = 1'b0; npc_op = 2'd0; rs_data = 32'h0; ack_delay = 2;
    mem[32'h3000] = 32'h2008_0005;
    mem[32'h3010] = 32'h1000_FFFE;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h3000);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_err", {31'b0, addr_err}, 32'd0);
    check("rst_retired", retired, 32'h0);

    m_pc = 32'h3000; m_ret = 32'h0;
    push_next();
    rstn = 1'b1;
    @(posedge clk); #1;
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h3000);
    @(negedge clk);

    commit(NPC_PLUS4, 32'h0, 0);
    mem[32'h3000] = 32'h0800_0C10;
    repeat (3) commit(NPC_PLUS4, 32'h0, 1);
    commit(NPC_BRANCH, 32'h0, 0);
    wait_valid();
    check("branch_pc", pc, 32'h300C);
    check("branch_retired", retired, 32'd5);

    // Stall with a spurious ack: nothing may move
    for (int i = 0; i < 10; i++) begin
      spur_ack = (i == 5);
      @(negedge clk);
      check("stall_instr", instr, mem_word(32'h300C));
      check("stall_pc", pc, 32'h300C);
      check("stall_retired", retired, 32'd5);
    end
    spur_ack = 1'b0;

    commit(NPC_JR, 32'h3000, 0);
    commit(NPC_JUMP, 32'h0, 0);
    wait_valid();
    check("jump_pc", pc, 32'h3040);
    commit(NPC_JR, 32'h3022, 0);
    n = 0;
    while (!addr_err && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      advance  = 1'b1;
      spur_ack = i[0];
      @(negedge clk);
      check("halt_hold_pc", pc, 32'h3022);
      check("halt_hold_err", {31'b0, addr_err}, 32'd1);
      check("halt_hold_req", {31'b0, imem_req}, 32'd0);
      check("halt_hold_valid", {31'b0, instr_valid}, 32'd0);
      check("halt_hold_retired", retired, 32'd8);
    end
    advance = 1'b0; spur_ack = 1'b0;

    rstn = 1'b0;
    repeat (2) @(negedge clk);
    ack_delay = 1;
    m_pc = 32'h3000; m_ret = 32'h0;
    push_next();
    rstn = 1'b1;

    for (int i = 0; i < 150; i++) begin
      ack_delay = $urandom_range(0, 3);
      commit(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
    end

    // Reset in the middle of an outstanding fetch
    wait_valid();
    ack_delay = 8;
    commit(NPC_PLUS4, 32'h0, 0);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h3000);
    check("midrst_retired", retired, 32'h0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_err", {31'b0, addr_err}, 32'd0);
    sb.delete();
    m_pc = 32'h3000; m_ret = 32'h0;
    @(negedge clk);
    spur_ack = 1'b1;
    push_next();
    rstn = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    ack_delay = 0;
    check("rerst_req", {31'b0, imem_req}, 32'd1);
    check("rerst_addr", imem_addr, 32'h3000);
    check("rerst_valid", {31'b0, instr_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      ack_delay = $urandom_range(0, 3);
      commit(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, 0);
    end
    repeat (10) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and fetches the instruction word from instruction memory over a req/ack handshake.
- Presents the instruction (Op/Funct fields and immediates) to the decoder, then computes the next PC from the decoder's 2-bit next-PC code when the datapath signals completion.
- Detects misaligned jump-register targets and halts fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC and instruction-memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- npc_op  in  2  next-PC code: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JR.
- rs_data  in  32  register value used as the JR target.
- advance  in  1  datapath commit pulse; the current instruction is complete.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction; [31:26] is Op, [5:0] is Funct.
- instr_valid  out  1  instr holds a fetched, uncommitted instruction.
- pc  out  ADDR_W  address of instr.
- pc_plus4  out  ADDR_W  pc+4, used for link writeback.
- addr_err  out  1  sticky misaligned-target flag.
- retired  out  32  count of committed instructions.

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, addr_err=0, retired=0, state=FETCH.
  - The reset takes effect immediately, including mid-fetch. Any pending ack is discarded.
- FSM states: FETCH, HOLD, HALT.
- FETCH:
  - imem_req=1 from the first clock edge after rstn deasserts.
  - imem_ack is honoured only while imem_req=1. Ack with req=0 is ignored.
  - On ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD. Minimum latency is one cycle from req to valid.
  - advance in FETCH is ignored.
- HOLD:
  - instr is stable and the decoder drives npc_op, rs_data and advance combinationally from it.
  - On advance:
    - pc<=next_pc, retired<=retired+1, instr_valid<=0.
    - If the target is aligned: imem_req<=1, go to FETCH.
    - If the target is misaligned: go to HALT.
  - With no advance, HOLD is held indefinitely. This is the stall behaviour.
- next_pc, with all arithmetic mod 2^32 and wrap-around allowed:
  - PLUS4: pc+4.
  - BRANCH: pc+4 + (sign_extend(instr[15:0])<<2).
  - JUMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - JR: rs_data.
- Misalignment: only JR can produce a misaligned target (rs_data[1:0]!=0). On advance in that case:
  - pc still loads rs_data, addr_err<=1, state<=HALT.
- HALT:
  - imem_req=0, instr_valid=0. advance and imem_ack are ignored.
  - Exit is by reset only.
- retired wraps 32'hFFFF_FFFF -> 0.
- An ack and advance in the same cycle cannot conflict: they are legal only in different states.
- imem_addr is driven from the pc register, never from next_pc. This makes the output glitch-free.

Decomposition:
- Shared package:
  - NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JR 2-bit constants.
  - FSM state encoding (FETCH=2'b00, HOLD=2'b01, HALT=2'b10).
  - RESET_PC default.
- One combinational sub-module, npc_calc:
  - Inputs: pc, instr[25:0], rs_data, npc_op.
  - Outputs: next_pc, misaligned.
  - It is instantiated once. The FSM, PC register, instruction register and counter stay in pc_fetch_unit.

Test Plan:
- Reset release, memory acks 2 cycles after req with 32'h2008_0005 -> imem_addr=32'h3000; instr_valid rises the cycle after ack; instr=32'h2008_0005; pc_plus4=32'h3004.
- HOLD, npc_op=01, instr[15:0]=16'hFFFE, pc=32'h3010, advance -> next fetch at 32'h300C; retired increments by 1.
- HOLD, npc_op=10, pc=32'h3000, instr[25:0]=26'h0000C10 -> next imem_addr=32'h0000_3040.
- HOLD, npc_op=11, rs_data=32'h3022, advance -> addr_err=1, imem_req stays 0, instr_valid=0; later ack and advance pulses produce no change.
- Stall: HOLD for 10 cycles without advance, with a spurious imem_ack -> instr, pc and retired unchanged.
- Reset asserted while imem_req=1 and before ack -> outputs return to reset values asynchronously; after release, imem_addr=32'h3000 and the stale ack is ignored.
